// File: rtl/byte_en_unpacker.sv
// byte_en_unpacker: accepts a data word with a byte-enable mask and emits
// the enabled bytes one per cycle, lowest lane first, with valid/ready
// handshakes on both sides.
module byte_en_unpacker #(
  parameter int DATA_W = 32,
  parameter int EN_W   = (DATA_W - 1) / 8 + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [EN_W-1:0]                       en,
  input  logic [DATA_W-1:0]                     d,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [7:0]                            out_byte,
  output logic [((EN_W > 1) ? $clog2(EN_W) : 1)-1:0] out_lane,
  output logic                                  out_last,
  output logic                                  busy
);

  localparam int LANE_W = (EN_W > 1) ? $clog2(EN_W) : 1;
  localparam int PAD_W  = EN_W * 8;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [EN_W-1:0]     pend_q, pend_d;

  logic [PAD_W-1:0]    word_pad;
  logic [EN_W-1:0]     lane_oh;
  logic [LANE_W-1:0]   lane_sel;
  logic [7:0]          lane_byte;
  logic                only_one;
  logic                take;
  logic                accept;

  // Lowest pending lane: isolate the least-significant set bit of the mask,
  // then derive its index and byte; the top lane is zero-extended to 8 bits.
  always_comb begin
    word_pad               = '0;
    word_pad[DATA_W-1:0]   = word_q;
    lane_oh                = pend_q & (~pend_q + 1'b1);
    lane_sel               = '0;
    lane_byte              = '0;
    for (int unsigned i = 0; i < EN_W; i++) begin
      if (lane_oh[i]) begin
        lane_sel  = LANE_W'(i);
        lane_byte = word_pad[8*i +: 8];
      end
    end
    only_one = ((pend_q & ~lane_oh) == '0);
  end

  // Output decode; byte/lane/last are forced to zero outside EMIT.
  always_comb begin
    out_valid = (state_q == EMIT);
    busy      = out_valid;
    out_byte  = out_valid ? lane_byte : 8'h00;
    out_lane  = out_valid ? lane_sel : '0;
    out_last  = out_valid && only_one;
    take      = out_valid && out_ready;
    in_ready  = (state_q == IDLE) || (take && out_last);
    accept    = in_valid && in_ready;
  end

  // Next-state: retire the presented lane on a transfer; a new word accepted
  // on the same edge as the final transfer overrides the return to IDLE.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pend_d  = pend_q;
    if (take) begin
      pend_d = pend_q & ~lane_oh;
      if (only_one) begin
        state_d = IDLE;
      end
    end
    if (accept) begin
      word_d  = d;
      pend_d  = en;
      state_d = (en != '0) ? EMIT : IDLE;
    end
  end

  // State, held word and pending mask; reset wins over any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_byte_en_unpacker.sv
// Self-checking bench for byte_en_unpacker: directed scenarios plus random
// traffic, scored against a queue-based model of the emitted byte stream.
module tb_byte_en_unpacker;

  localparam int DW = 32;
  localparam int EW = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] en = '0;
  logic [DW-1:0] d = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_byte;
  logic [LW-1:0] out_lane;
  logic          out_last;
  logic          busy;

  // Second build with a width that is not a multiple of 8.
  logic          in_valid31 = 1'b0;
  logic          in_ready31;
  logic [3:0]    en31 = '0;
  logic [30:0]   d31 = '0;
  logic          out_valid31;
  logic [7:0]    out_byte31;
  logic [1:0]    out_lane31;
  logic          out_last31;
  logic          busy31;

  always #5 clk = ~clk;

  byte_en_unpacker #(.DATA_W(DW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .en(en), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_lane(out_lane), .out_last(out_last), .busy(busy)
  );

  byte_en_unpacker #(.DATA_W(31)) u_dut31 (
    .clk(clk), .rst(rst), .in_valid(in_valid31), .in_ready(in_ready31),
    .en(en31), .d(d31), .out_valid(out_valid31), .out_ready(1'b1),
    .out_byte(out_byte31), .out_lane(out_lane31), .out_last(out_last31), .busy(busy31)
  );

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] lane;
    logic       last;
  } item_t;

  item_t      exp_q[$];
  logic [7:0] log_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance
  // the model to what the coming rising edge does.
  task automatic step(input logic r, input logic iv, input logic [3:0] e,
                      input logic [31:0] dd, input logic ordy);
    item_t h;
    logic  have;
    logic  exp_rdy;
    @(negedge clk);
    rst = r; in_valid = iv; en = e; d = dd; out_ready = ordy;
    #1;
    have = (exp_q.size() > 0);
    h    = have ? exp_q[0] : '0;
    check("out_valid", out_valid, have);
    check("busy", busy, have);
    check("out_byte", out_byte, h.b);
    check("out_lane", out_lane, h.lane);
    check("out_last", out_last, h.last);
    exp_rdy = !have || (ordy && h.last);
    check("in_ready", in_ready, exp_rdy);
    if (r) begin
      exp_q.delete();
    end else begin
      if (have && ordy) begin
        log_q.push_back(h.b);
        void'(exp_q.pop_front());
      end
      if (iv && exp_rdy) begin
        for (int i = 0; i < EW; i++) begin
          if (e[i]) begin
            exp_q.push_back('{b: dd[8*i +: 8], lane: 2'(i), last: ((e >> (i + 1)) == 0)});
          end
        end
      end
    end
  endtask

  task automatic check_log(input string tag, input logic [31:0] exp_bytes, input int n);
    check({tag, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check(tag, log_q[i], exp_bytes[8*i +: 8]);
    end
    log_q.delete();
  endtask

  initial begin
    step(1, 0, 4'h0, 0, 0);
    step(1, 1, 4'hf, 32'hffffffff, 1);   // accept ignored under reset
    step(0, 0, 4'h0, 0, 0);
    log_q.delete();

    // Full mask
    step(0, 1, 4'hf, 32'h12345678, 1);
    repeat (4) step(0, 0, 4'h0, 0, 1);
    step(0, 0, 4'h0, 0, 1);
    check_log("full", 32'h12345678, 4);

    // Sparse mask
    step(0, 1, 4'ha, 32'hdeadbeef, 1);
    repeat (3) step(0, 0, 4'h0, 0, 1);
    check_log("sparse", 32'h0000debe, 2);

    // Empty mask, then a single-lane word
    step(0, 1, 4'h0, 32'h55555555, 1);
    step(0, 1, 4'h1, 32'h000000aa, 1);
    repeat (2) step(0, 0, 4'h0, 0, 1);
    check_log("empty", 32'h000000aa, 1);

    // Backpressure
    step(0, 1, 4'h3, 32'h0000c0de, 0);
    repeat (3) step(0, 0, 4'h0, 0, 0);
    repeat (3) step(0, 0, 4'h0, 0, 1);
    check_log("bp", 32'h0000c0de, 2);

    // Back-to-back words
    step(0, 1, 4'h8, 32'h11000000, 1);
    step(0, 1, 4'h1, 32'h00000022, 1);
    step(0, 0, 4'h0, 0, 1);
    step(0, 0, 4'h0, 0, 1);
    check_log("b2b", 32'h00002211, 2);

    // Reset mid-word
    step(0, 1, 4'hf, 32'h12345678, 1);
    step(0, 0, 4'h0, 0, 1);
    step(0, 0, 4'h0, 0, 1);
    step(1, 0, 4'h0, 0, 1);
    repeat (3) step(0, 0, 4'h0, 0, 1);
    check_log("rst_mid", 32'h00005678, 2);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 4'($urandom),
           $urandom, ($urandom_range(0, 9) < 7));
    end
    for (int n = 0; n < 8; n++) step(0, 0, 4'h0, 0, 1);
    check("drained", exp_q.size(), 0);

    // 31-bit build: top lane zero-extended
    @(negedge clk);
    in_valid31 = 1'b1; en31 = 4'h8; d31 = 31'h7f000000;
    @(negedge clk);
    in_valid31 = 1'b0;
    #1;
    check("w31_valid", out_valid31, 1'b1);
    check("w31_byte", out_byte31, 8'h7f);
    check("w31_lane", out_lane31, 2'd3);
    check("w31_last", out_last31, 1'b1);
    @(negedge clk);
    #1;
    check("w31_idle", out_valid31, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
